// File: rtl/seg7_scan_driver_if.sv
// Display bus for seg7_scan_driver: digit/control inputs on one side and
// the multiplexed common-anode display drive on the other.
// There is no handshake on this bus. The producer holds digits, dp_mask and
// blank_lz at its current value. The driver samples all three only on the
// edge that starts a frame. The display outputs are free-running registered
// levels.
interface seg7_scan_driver_if;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic [3:0]  anode_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_start;

    modport master (
        output digits, dp_mask, blank_lz,
        input  anode_n, seg_n, dp_n, frame_start
    );

    modport slave (
        input  digits, dp_mask, blank_lz,
        output anode_n, seg_n, dp_n, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver.
// Each digit slot is SLOT_CYCLES long. The first cycle of every slot is a
// blank guard cycle that stops ghosting between digits. The four digits,
// the dp mask and blank_lz are snapshotted once per frame so a display never
// mixes two input values. All outputs are registered. The register values
// always describe the cycle being shown now.
// SLOT_CYCLES must be in 2..65535.
module seg7_scan_driver #(
    parameter int unsigned SLOT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);

    // Position of the cycle currently on the display.
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    // Cleared by reset. The first edge after release enters slot 0 without advancing.
    logic          running;
    logic [15:0]   snap_digits;
    logic [3:0]    snap_dp;
    logic          snap_blz;

    logic [CW-1:0] cnt_nx;
    logic [1:0]    idx_nx;
    logic          enter_frame;
    logic [15:0]   snap_digits_nx;
    logic [3:0]    snap_dp_nx;
    logic          snap_blz_nx;
    logic [3:0]    nib;
    logic          lz_blank;
    logic [3:0]    anode_nx;
    logic [6:0]    seg_nx;
    logic          dp_nx;
    logic          frame_start_nx;

    // Active-low {g,f,e,d,c,b,a}. Non-BCD codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Advance the scan position and pick up a new snapshot at each frame start.
    always_comb begin
        cnt_nx = cnt;
        idx_nx = idx;
        if (running) begin
            if (cnt == CNT_LAST) begin
                cnt_nx = '0;
                idx_nx = idx + 2'd1;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end
        enter_frame    = (cnt_nx == '0) && (idx_nx == 2'd0);
        snap_digits_nx = snap_digits;
        snap_dp_nx     = snap_dp;
        snap_blz_nx    = snap_blz;
        if (enter_frame) begin
            snap_digits_nx = bus.digits;
            snap_dp_nx     = bus.dp_mask;
            snap_blz_nx    = bus.blank_lz;
        end
    end

    // Select the digit for the next slot and decide whether it is a leading zero.
    always_comb begin
        nib      = 4'd0;
        lz_blank = 1'b0;
        case (idx_nx)
            2'd0: nib = snap_digits_nx[3:0];
            2'd1: nib = snap_digits_nx[7:4];
            2'd2: nib = snap_digits_nx[11:8];
            default: nib = snap_digits_nx[15:12];
        endcase
        // A digit is blanked only when it and every higher digit are zero.
        case (idx_nx)
            2'd1: lz_blank = (snap_digits_nx[15:4] == 12'd0);
            2'd2: lz_blank = (snap_digits_nx[15:8] == 8'd0);
            2'd3: lz_blank = (snap_digits_nx[15:12] == 4'd0);
            default: lz_blank = 1'b0;
        endcase
        lz_blank = lz_blank & snap_blz_nx;
    end

    // Build the drive for the next cycle: all off on guard cycles, one anode otherwise.
    always_comb begin
        anode_nx       = 4'b1111;
        seg_nx         = 7'b1111111;
        dp_nx          = 1'b1;
        frame_start_nx = 1'b0;
        if (cnt_nx == '0) begin
            frame_start_nx = (idx_nx == 2'd0);
        end else begin
            anode_nx         = 4'b1111;
            anode_nx[idx_nx] = 1'b0;
            seg_nx           = lz_blank ? 7'b1111111 : seg_decode(nib);
            dp_nx            = ~snap_dp_nx[idx_nx];
        end
    end

    // Register scan position, snapshot and display outputs. Reset blanks at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt             <= '0;
            idx             <= 2'd0;
            running         <= 1'b0;
            snap_digits     <= 16'h0000;
            snap_dp         <= 4'h0;
            snap_blz        <= 1'b0;
            bus.anode_n     <= 4'b1111;
            bus.seg_n       <= 7'b1111111;
            bus.dp_n        <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            cnt             <= cnt_nx;
            idx             <= idx_nx;
            running         <= 1'b1;
            snap_digits     <= snap_digits_nx;
            snap_dp         <= snap_dp_nx;
            snap_blz        <= snap_blz_nx;
            bus.anode_n     <= anode_nx;
            bus.seg_n       <= seg_nx;
            bus.dp_n        <= dp_nx;
            bus.frame_start <= frame_start_nx;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver. A frame-position model predicts every output
// cycle from the display rules. Directed test-plan steps are followed by a
// randomized phase.
module tb_seg7_scan_driver;
    localparam int S     = 4;
    localparam int FRAME = 4 * S;

    logic clk;
    logic reset;
    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.SLOT_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Model state: cycles since reset release (-1 = held in reset).
    int          m_k = -1;
    logic [15:0] s_dig;
    logic [3:0]  s_dp;
    logic        s_blz;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fs;

    function automatic logic [6:0] seg_rom(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s k=%0d got=%h exp=%h", tag, m_k, got, exp);
        end
    endtask

    // One clock: model the edge, then compare all outputs 1 time unit later.
    task automatic step();
        int p;
        int slot;
        int c;
        int val;
        @(posedge clk);
        if (reset) begin
            m_k   = -1;
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
            e_dp  = 1'b1;
            e_fs  = 1'b0;
        end else begin
            m_k++;
            p = m_k % FRAME;
            if (p == 0) begin
                s_dig = bus.digits;
                s_dp  = bus.dp_mask;
                s_blz = bus.blank_lz;
            end
            slot = p / S;
            c    = p % S;
            if (c == 0) begin
                e_an  = 4'b1111;
                e_seg = 7'b1111111;
                e_dp  = 1'b1;
                e_fs  = (slot == 0);
            end else begin
                e_an = 4'(~(4'b0001 << slot));
                val  = int'(s_dig) >> (4 * slot);
                if (s_blz && slot > 0 && val == 0)
                    e_seg = 7'b1111111;
                else
                    e_seg = seg_rom(val % 16);
                e_dp = ~s_dp[slot];
                e_fs = 1'b0;
            end
        end
        #1;
        check("anode_n", 16'(bus.anode_n), 16'(e_an));
        check("seg_n", 16'(bus.seg_n), 16'(e_seg));
        check("dp_n", 16'(bus.dp_n), 16'(e_dp));
        check("frame_start", 16'(bus.frame_start), 16'(e_fs));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the model sits at frame position p (bounded to two frames).
    task automatic run_to_pos(input int p);
        int guard;
        guard = 0;
        while ((m_k < 0 || (m_k % FRAME) != p) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        vectors++;
        assert (guard < 2 * FRAME) else begin
            miscompares++;
            $error("FAIL run_to_pos timeout got=%0d exp=%0d", m_k % FRAME, p);
        end
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        d = 16'h0;
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 1) == 1) d[4*i +: 4] = 4'($urandom_range(0, 15));
        return d;
    endfunction

    initial begin
        reset        = 1'b1;
        bus.digits   = 16'h1234;
        bus.dp_mask  = 4'b0000;
        bus.blank_lz = 1'b0;
        run(2);

        // 1234, no blanking: first cycle after release is the slot-0 guard.
        reset = 1'b0;
        step();
        check("tp_first_fs", 16'(bus.frame_start), 16'd1);
        step();
        check("tp_d0_anode", 16'(bus.anode_n), 16'b1110);
        check("tp_d0_seg", 16'(bus.seg_n), 16'b0011001);
        run(2 * FRAME);

        // 0050 with and without leading-zero blanking.
        bus.digits   = 16'h0050;
        bus.blank_lz = 1'b1;
        run(2 * FRAME);
        bus.blank_lz = 1'b0;
        run(FRAME);

        // All zero, blanked, dp on digit 2.
        bus.digits   = 16'h0000;
        bus.blank_lz = 1'b1;
        bus.dp_mask  = 4'b0100;
        run(2 * FRAME);

        // Mid-frame input change is deferred to the next frame.
        bus.digits   = 16'h1234;
        bus.blank_lz = 1'b0;
        bus.dp_mask  = 4'b0000;
        run_to_pos(15);
        run_to_pos(6);
        bus.digits = 16'h5678;
        run(FRAME + 4);

        // Non-BCD codes show a dash.
        bus.digits = 16'hAF09;
        run(2 * FRAME);

        // Reset mid-frame at position 9.
        run_to_pos(9);
        reset = 1'b1;
        step();
        check("tp_rst_anode", 16'(bus.anode_n), 16'b1111);
        reset      = 1'b0;
        bus.digits = 16'h4321;
        step();
        check("tp_rst_fs", 16'(bus.frame_start), 16'd1);
        run(FRAME);

        // Randomized phase: inputs change at random cycles, occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                bus.digits   = rand_digits();
                bus.dp_mask  = 4'($urandom_range(0, 15));
                bus.blank_lz = 1'($urandom_range(0, 1));
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        run(FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
